bin_bcd_serializer: RTL
=======================

# bin_bcd_serializer

Converts an unsigned binary word into packed BCD with a sequential shift-and-add-3 (double-dabble) engine, then streams the BCD digits out one per handshake, most significant digit first. It sits directly upstream of the BCD-to-Excess-3 converter: each emitted 4-bit digit drives that converter's A,B,C,D inputs. Output digits are always legal BCD (0-9), so the converter never sees codes 10-15.

## Interface
- BIN_W, 8, width of the binary input.
- NDIG, 3, number of BCD digits produced; legal only when 10^NDIG > 2^BIN_W - 1 (default pair 8/3 covers 0-255).
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  bin_in is valid.
- in_ready  output  1  block can accept a new word; high only in IDLE.
- bin_in  input  BIN_W  unsigned binary value.
- dig_valid  output  1  dig_out holds a valid digit.
- dig_ready  input  1  downstream accepts dig_out.
- dig_out  output  4  BCD digit; bit3 = A (MSB) ... bit0 = D (LSB).
- dig_idx  output  2  digit position, NDIG-1 = most significant, 0 = units.
- dig_last  output  1  high with the units digit (dig_idx = 0).

## Operation
- States: IDLE, CONVERT, EMIT.
- IDLE: in_ready = 1, dig_valid = 0. On in_valid & in_ready at a clock edge: capture bin_in into shift register, clear BCD register (4*NDIG bits), load step counter with BIN_W, go to CONVERT.
- CONVERT: one step per cycle. Each step: for every BCD nibble >= 5, add 3 (per nibble, no carry between nibbles); then shift the {BCD, binary} concatenation left by one, so the binary MSB enters BCD bit 0. Decrement the step counter; after BIN_W steps go to EMIT with digit pointer = NDIG-1.
- EMIT: dig_valid = 1, dig_out = BCD nibble at pointer, dig_idx = pointer, dig_last = (pointer == 0). On dig_valid & dig_ready: if pointer == 0 go to IDLE, else decrement pointer.
- All NDIG digits are always emitted, leading zeros included.
- in_valid outside IDLE is ignored; no input buffering. bin_in need only be stable at the accepting edge.
- dig_out, dig_idx and dig_last hold stable while dig_valid & !dig_ready.
- Reset (any state, any time): state IDLE, registers cleared; any conversion or partial emission in progress is discarded and never resumed.

## Timing
- Reset values: in_ready = 1, dig_valid = 0, dig_out = 0, dig_idx = 0, dig_last = 0.
- Accept at edge T0; CONVERT steps at edges T1..T_BIN_W; dig_valid rises after edge T_BIN_W (BIN_W cycles after acceptance, 8 by default).
- With dig_ready held high, one digit per cycle; the last digit handshake returns to IDLE, in_ready high the following cycle.
- Throughput with no backpressure: one word per BIN_W + NDIG + 1 cycles (12 by default).
- in_ready and dig_valid are decoded from registered state only; no combinational path from in_valid or dig_ready to either.
- dig_ready low stalls EMIT indefinitely with no loss or change of data.

## Test plan
- Reset then bin_in = 0 with dig_ready = 1 -> dig_valid rises 8 cycles after accept; digits 0,0,0 with dig_idx 2,1,0; dig_last only on the third.
- bin_in = 255 -> digits 2,5,5 on consecutive cycles; in_ready returns 12 cycles after the first accept.
- bin_in = 137, dig_ready toggled 0,0,1,0,1,1 -> digits 1,3,7, each held stable through stall cycles, no duplicates or drops.
- Back-to-back words 99 then 100 with in_valid held high -> 0,9,9 then 1,0,0; second word accepted only in the cycle in_ready is high; in_valid during CONVERT/EMIT has no effect.
- Assert rst at step 4 of converting 200, and again after the first digit of a second word -> outputs return to reset values immediately; the next word (42) yields 0,4,2 cleanly.
- Sweep all bin_in 0-255 -> every dig_out in 0-9 and the concatenated digits equal the decimal value.

Source files
------------

// File: rtl/bin_bcd_serializer.sv
// Binary-to-BCD converter with a sequential double-dabble engine and a
// digit-serial output port that emits the most significant digit first.
//
// Handshake rule for both ports: a transfer happens on a rising clock edge
// where valid and ready are both high. in_ready and dig_valid come only from
// registered state. While dig_valid is high and dig_ready is low, dig_out,
// dig_idx and dig_last hold their values.
module bin_bcd_serializer #(
   parameter int BIN_W = 8,
   parameter int NDIG  = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BIN_W-1:0] bin_in,
   output logic             dig_valid,
   input  logic             dig_ready,
   output logic [3:0]       dig_out,
   output logic [1:0]       dig_idx,
   output logic             dig_last
);

   localparam int BCD_W = 4 * NDIG;
   localparam int CW    = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_EMIT    = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   bin_q,   bin_d;
   logic [BCD_W-1:0]   bcd_q,   bcd_d;
   logic [CW-1:0]      cnt_q,   cnt_d;
   logic [1:0]         ptr_q,   ptr_d;

   logic [BCD_W-1:0]   bcd_adj;
   logic [BCD_W-1:0]   bcd_sh;
   logic [BIN_W-1:0]   bin_sh;
   logic [3:0]         cur_nibble;

   // One double-dabble step: add 3 to each nibble >= 5, then shift {bcd, bin} left.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < NDIG; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      bcd_sh = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
      bin_sh = {bin_q[BIN_W-2:0], 1'b0};
   end

   // Output decode from registered state; digit fields read zero outside EMIT.
   always_comb begin
      cur_nibble = bcd_q[4*int'(ptr_q) +: 4];
      in_ready   = (state_q == S_IDLE);
      dig_valid  = (state_q == S_EMIT);
      dig_out    = 4'd0;
      dig_idx    = 2'd0;
      dig_last   = 1'b0;
      if (state_q == S_EMIT) begin
         dig_out  = cur_nibble;
         dig_idx  = ptr_q;
         dig_last = (ptr_q == 2'd0);
      end
   end

   // Next-state logic: accept a word, run BIN_W conversion steps, then emit digits.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               bin_d   = bin_in;
               bcd_d   = '0;
               cnt_d   = CW'(BIN_W);
               state_d = S_CONVERT;
            end
         end
         S_CONVERT: begin
            bin_d = bin_sh;
            bcd_d = bcd_sh;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               ptr_d   = 2'(NDIG - 1);
               state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            if (dig_ready) begin
               if (ptr_q == 2'd0) begin
                  state_d = S_IDLE;
               end else begin
                  ptr_d = ptr_q - 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any word in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   end

endmodule
